// File: rtl/pattern_sched_pkg.sv
// Shared encodings for the test-pattern mode scheduler: pattern ids, FSM states, pending-step codes.
package pattern_sched_pkg;

    typedef enum logic [3:0] {
        MODE_BLACK      = 4'd0,
        MODE_WHITE      = 4'd1,
        MODE_RED        = 4'd2,
        MODE_GREEN      = 4'd3,
        MODE_BLUE       = 4'd4,
        MODE_GRAY_RAMP  = 4'd5,
        MODE_RED_RAMP   = 4'd6,
        MODE_GREEN_RAMP = 4'd7,
        MODE_BLUE_RAMP  = 4'd8,
        MODE_CHECKER    = 4'd9,
        MODE_HSTRIPES   = 4'd10,
        MODE_VSTRIPES   = 4'd11,
        MODE_COLORBAR   = 4'd12
    } pattern_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AUTO   = 2'd1,
        MANUAL = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2
    } step_e;

endpackage

// File: rtl/btn_debounce.sv
// Level debouncer: output follows the input only after CYCLES consecutive samples that differ from it.
module btn_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;

    // Any sample equal to the current level restarts the stability count.
    always_comb begin
        cnt_d = '0;
        q_d   = q_q;
        if (d_i != q_q) begin
            if (cnt_q == CNT_LAST) begin
                q_d = d_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pattern_mode_scheduler.sv
// Test-pattern mode sequencer: auto or button-driven mode steps, applied only at frame start.
// Build macro PATSCHED_DEBOUNCE_EN inserts a btn_debounce after each button synchroniser.
module pattern_mode_scheduler
    import pattern_sched_pkg::*;
#(
    parameter int NUM_MODES       = 13,
    parameter int FRAMES_PER_MODE = 128,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MODE_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync_i,
    input  logic              auto_en_i,
    input  logic              btn_next_i,
    input  logic              btn_prev_i,
    output logic [MODE_W-1:0] mode_o,
    output logic              mode_change_o,
    output logic [7:0]        frame_cnt_o
);
    localparam int                CNT_W     = $clog2(FRAMES_PER_MODE + 1);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAMES_PER_MODE - 1);

    if (NUM_MODES < 2 || FRAMES_PER_MODE < 1 || DEBOUNCE_CYCLES < 1 ||
        (2 ** MODE_W) < NUM_MODES) begin : g_param_check
        $error("pattern_mode_scheduler: invalid parameter set");
    end

    logic [1:0]        btn_raw, btn_lvl, press;
    logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d, lvl_prev_q, lvl_prev_d;
    logic              vsync_q, vsync_d, arm_q, arm_d;
    logic              fs, press_next, press_prev;
    sched_state_e      state_q, state_d, run_state;
    step_e             step_q, step_d;
    logic [MODE_W-1:0] mode_q, mode_d, mode_inc, mode_dec;
    logic              chg_q, chg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W+7:0]  cnt_ext;

    assign btn_raw = {btn_prev_i, btn_next_i};

`ifdef PATSCHED_DEBOUNCE_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk (clk),
            .rst (rst),
            .d_i (sync2_q[gi]),
            .q_o (btn_lvl[gi])
        );
    end
`else
    assign btn_lvl = sync2_q;
`endif

    // Simultaneous next+prev cancel each other.
    assign press      = btn_lvl & ~lvl_prev_q;
    assign press_next = press[0] & ~press[1];
    assign press_prev = press[1] & ~press[0];

    // arm_q keeps a vsync already low at reset release from counting as a frame start.
    assign fs        = arm_q & vsync_q & ~vsync_i;
    assign run_state = auto_en_i ? AUTO : MANUAL;
    assign mode_inc  = (mode_q == LAST_MODE) ? '0 : mode_q + 1'b1;
    assign mode_dec  = (mode_q == '0) ? LAST_MODE : mode_q - 1'b1;

    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        lvl_prev_d = btn_lvl;
        vsync_d    = vsync_i;
        arm_d      = arm_q | vsync_i;

        step_d = step_q;
        if (fs) begin
            step_d = STEP_NONE;
        end else if (step_q == STEP_NONE && press_next) begin
            step_d = STEP_INC;
        end else if (step_q == STEP_NONE && press_prev) begin
            step_d = STEP_DEC;
        end

        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (fs) begin
                state_d = run_state;
            end
        end else begin
            state_d = run_state;
            if (fs) begin
                // >= so a count carried over from MANUAL past the hold length still advances.
                if (step_q == STEP_INC) begin
                    mode_d = mode_inc;
                    cnt_d  = '0;
                end else if (step_q == STEP_DEC) begin
                    mode_d = mode_dec;
                    cnt_d  = '0;
                end else if (run_state == AUTO && cnt_q >= CNT_LAST) begin
                    mode_d = mode_inc;
                    cnt_d  = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        chg_d = (mode_d != mode_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_prev_q <= '0;
            vsync_q    <= 1'b1;
            arm_q      <= 1'b0;
            state_q    <= IDLE;
            step_q     <= STEP_NONE;
            mode_q     <= MODE_W'(MODE_BLACK);
            chg_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_prev_q <= lvl_prev_d;
            vsync_q    <= vsync_d;
            arm_q      <= arm_d;
            state_q    <= state_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            chg_q      <= chg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mode_o        = mode_q;
    assign mode_change_o = chg_q;
    assign cnt_ext       = {8'd0, cnt_q};
    assign frame_cnt_o   = (cnt_ext > (CNT_W + 8)'(255)) ? 8'hFF : cnt_ext[7:0];

endmodule

// File: tb/tb_pattern_mode_scheduler.sv
// Self-checking bench for pattern_mode_scheduler: directed frame table, reset sequence, random frames.
module tb_pattern_mode_scheduler;
    localparam int NM      = 4;
    localparam int FPM     = 2;
    localparam int DEB     = 4;
    localparam int MW      = 4;
    localparam int CNT_MAX = (1 << $clog2(FPM + 1)) - 1;
`ifdef PATSCHED_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vsync = 1'b1;
    logic          auto_en = 1'b1;
    logic          bn = 1'b0;
    logic          bp = 1'b0;
    logic [MW-1:0] mode;
    logic          chg;
    logic [7:0]    fcnt;

    pattern_mode_scheduler #(
        .NUM_MODES(NM), .FRAMES_PER_MODE(FPM), .DEBOUNCE_CYCLES(DEB), .MODE_W(MW)
    ) dut (
        .clk(clk), .rst(rst), .vsync_i(vsync), .auto_en_i(auto_en),
        .btn_next_i(bn), .btn_prev_i(bp),
        .mode_o(mode), .mode_change_o(chg), .frame_cnt_o(fcnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model, tracked at frame/press granularity.
    bit m_started;
    int m_mode, m_cnt, m_pend;
    bit m_chg;
    logic fs_chg_seen;

    typedef struct {
        bit ae_mid;
        bit ae_fs;
        int kind;
        int exp_mode;
        bit exp_chg;
        int exp_cnt;
    } frame_vec_t;

    frame_vec_t tbl[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int wrap(input int m);
        return ((m % NM) + NM) % NM;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_mode = 0;
        m_cnt = 0;
        m_pend = 0;
        m_chg = 1'b0;
    endtask

    // code: 0 none, 1 next, 2 prev, 3 both at once
    task automatic model_ev(input int code, input int hold);
        if (code == 1 || code == 2) begin
            if (!(DEB_EN && hold < DEB) && m_pend == 0)
                m_pend = (code == 1) ? 1 : -1;
        end
    endtask

    task automatic model_fs();
        int old;
        old = m_mode;
        if (!m_started) begin
            m_started = 1'b1;
        end else begin
            if (m_pend != 0) begin
                m_mode = wrap(m_mode + m_pend);
                m_cnt = 0;
            end else if (auto_en && m_cnt >= FPM - 1) begin
                m_mode = wrap(m_mode + 1);
                m_cnt = 0;
            end else begin
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end
        end
        m_chg = (m_mode != old);
        m_pend = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        check("mode", mode, m_mode);
        check("pulse", chg, m_chg);
        check("fcnt", fcnt, (m_cnt > 255) ? 255 : m_cnt);
        m_chg = 1'b0;
    endtask

    task automatic get_ev(input int kind, output int c0, output int h0, output int c1, output int h1);
        c0 = 0; h0 = 6; c1 = 0; h1 = 6;
        case (kind)
            1: c0 = 1;
            2: c0 = 2;
            3: c0 = 3;
            4: begin c0 = 1; c1 = 1; end
            5: begin c0 = 1; c1 = 2; end
            6: begin c0 = 2; c1 = 1; end
            7: begin c0 = 1; h0 = 3; end
            8: begin c0 = 3; c1 = 2; end
            default: ;
        endcase
    endtask

    // One frame: 30 cycles vsync high with button activity, frame start, 4 more cycles low.
    task automatic run_frame(input bit ae_mid, input bit ae_fs, input int kind);
        int c0, h0, c1, h1;
        get_ev(kind, c0, h0, c1, h1);
        for (int i = 0; i < 30; i++) begin
            tick();
            vsync = 1'b1;
            bn = (i >= 2 && i < 2 + h0 && c0[0]) || (i >= 16 && i < 16 + h1 && c1[0]);
            bp = (i >= 2 && i < 2 + h0 && c0[1]) || (i >= 16 && i < 16 + h1 && c1[1]);
            if (i == 10) auto_en = ae_mid;
            if (i == 2) model_ev(c0, h0);
            if (i == 16) model_ev(c1, h1);
        end
        tick();
        auto_en = ae_fs;
        vsync = 1'b0;
        model_fs();
        tick();
        fs_chg_seen = chg;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        int exp_m[5];
        int exp_c[5];
        bit ae_mid, ae_fs;

        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 0, 1, 1, 0};
        tbl[3]  = '{1, 1, 0, 1, 0, 1};
        tbl[4]  = '{1, 1, 0, 2, 1, 0};
        tbl[5]  = '{1, 1, 0, 2, 0, 1};
        tbl[6]  = '{1, 1, 0, 3, 1, 0};
        tbl[7]  = '{1, 1, 0, 3, 0, 1};
        tbl[8]  = '{1, 1, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 2, 3, 1, 0};
        tbl[10] = '{0, 0, 4, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 3, 0, 0, 2};
        tbl[13] = '{0, 0, 8, 3, 1, 0};
        tbl[14] = '{0, 0, 0, 3, 0, 1};
        tbl[15] = '{0, 0, 0, 3, 0, 2};
        tbl[16] = '{1, 1, 1, 0, 1, 0};
        tbl[17] = '{1, 1, 0, 0, 0, 1};
        tbl[18] = '{1, 1, 2, 3, 1, 0};
        tbl[19] = '{1, 1, 0, 3, 0, 1};
        tbl[20] = '{1, 1, 0, 0, 1, 0};
        tbl[21] = '{1, 0, 0, 0, 0, 1};
        tbl[22] = '{0, 1, 0, 1, 1, 0};
        tbl[23] = '{0, 0, 7, DEB_EN ? 1 : 2, DEB_EN ? 1'b0 : 1'b1, DEB_EN ? 1 : 0};
        tbl[24] = '{0, 0, 1, DEB_EN ? 2 : 3, 1, 0};
        exp_m = '{0, 0, 1, 1, 2};
        exp_c = '{0, 1, 0, 1, 0};

        // Reset state
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Directed frames
        for (int k = 0; k < 25; k++) begin
            run_frame(tbl[k].ae_mid, tbl[k].ae_fs, tbl[k].kind);
            check($sformatf("tbl%0d_mode", k), mode, tbl[k].exp_mode);
            check($sformatf("tbl%0d_pulse", k), fs_chg_seen, tbl[k].exp_chg);
            check($sformatf("tbl%0d_fcnt", k), fcnt, tbl[k].exp_cnt);
            $display("frame %0d: mode=%0d pulse=%0b fcnt=%0d", k, mode, fs_chg_seen, fcnt);
        end

        // Reach mode 2 in AUTO, then reset mid-frame
        for (int k = 0; k < 12; k++) begin
            if (m_mode == 2) break;
            run_frame(1'b1, 1'b1, 0);
        end
        check("pre_rst_mode", mode, 2);
        vsync = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        #3 rst = 1'b1;
        #1;
        check("async_rst_mode", mode, 0);
        check("async_rst_fcnt", fcnt, 0);
        check("async_rst_pulse", chg, 0);
        model_reset();
        tick();
        vsync = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int k = 0; k < 5; k++) begin
            run_frame(1'b1, 1'b1, 0);
            check($sformatf("post_rst%0d_mode", k), mode, exp_m[k]);
            check($sformatf("post_rst%0d_fcnt", k), fcnt, exp_c[k]);
            $display("post-reset frame %0d: mode=%0d fcnt=%0d", k, mode, fcnt);
        end

        // Random frames against the model
        for (int k = 0; k < 40; k++) begin
            ae_mid = 1'($urandom_range(0, 1));
            ae_fs = ($urandom_range(0, 3) == 0) ? ~ae_mid : ae_mid;
            run_frame(ae_mid, ae_fs, int'($urandom_range(0, 8)));
            $display("random frame %0d: auto=%0b mode=%0d pulse=%0b fcnt=%0d", k, ae_fs, mode, fs_chg_seen, fcnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
